store_align_unit: RTL and testbench

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_unit.sv | 140 ++++++++++++++
 tb/tb_store_align_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Store alignment unit: positions a right-justified store onto memory byte lanes.
// A store that crosses a word boundary is issued as two write beats.
module store_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic                  done,
    output logic                  err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    state_t              state;
    logic                idle_q;
    logic                split_q;
    logic [ADDR_W-1:0]   hi_addr;
    logic [NB-1:0]       hi_be;
    logic [DATA_W-1:0]   hi_wdata;

    logic [OFS_W-1:0]    ofs;
    logic [ADDR_W-1:0]   base;
    logic [NB-1:0]       mask;
    logic [DATA_W-1:0]   data_m;
    logic [2*NB-1:0]     be2;
    logic [2*DATA_W-1:0] wd2;
    logic                too_big;
    logic                accept;

    // idle_q comes out of reset set, so the unit is ready in the first cycle after release
    assign req_ready = idle_q & ~reset;
    assign accept    = req_valid & req_ready;

    always_comb begin
        ofs             = req_addr[OFS_W-1:0];
        base            = req_addr;
        base[OFS_W-1:0] = '0;
        too_big         = (int'(req_size) > OFS_W);
        mask            = '0;
        data_m          = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << req_size)) begin
                mask[i]         = 1'b1;
                data_m[8*i +: 8] = req_data[8*i +: 8];
            end
        end
        be2 = {{NB{1'b0}}, mask} << ofs;
        wd2 = {{DATA_W{1'b0}}, data_m} << {ofs, 3'b000};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idle_q    <= 1'b1;
            split_q   <= 1'b0;
            hi_addr   <= '0;
            hi_be     <= '0;
            hi_wdata  <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    mem_valid <= 1'b0;
                    mem_be    <= '0;
                    if (accept) begin
                        if (too_big) begin
                            err <= 1'b1;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_addr  <= base;
                            mem_be    <= be2[NB-1:0];
                            mem_wdata <= wd2[DATA_W-1:0];
                            hi_addr   <= base + ADDR_W'(NB);
                            hi_be     <= be2[2*NB-1:NB];
                            hi_wdata  <= wd2[2*DATA_W-1:DATA_W];
                            split_q   <= (be2[2*NB-1:NB] != '0);
                            idle_q    <= 1'b0;
                            state     <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            mem_addr  <= hi_addr;
                            mem_be    <= hi_be;
                            mem_wdata <= hi_wdata;
                            state     <= BEAT1;
                        end else begin
                            mem_valid <= 1'b0;
                            mem_be    <= '0;
                            done      <= 1'b1;
                            idle_q    <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_be    <= '0;
                        done      <= 1'b1;
                        idle_q    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: table vectors, hand-written corner sequences and
// random stores checked against a byte-by-byte placement model.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, mem_valid, mem_ready, done, err;
    logic [31:0] req_addr, mem_addr, req_data, mem_wdata;
    logic [1:0]  req_size;
    logic [3:0]  mem_be;

    logic        w_req_valid, w_req_ready, w_mem_valid, w_mem_ready, w_done, w_err;
    logic [31:0] w_req_addr, w_mem_addr;
    logic [63:0] w_req_data, w_mem_wdata;
    logic [1:0]  w_req_size;
    logic [7:0]  w_mem_be;

    store_align_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .done(done), .err(err)
    );

    store_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
        .req_size(w_req_size), .req_data(w_req_data),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_be(w_mem_be), .done(w_done), .err(w_err)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] got_addr[$];
    logic [3:0]  got_be[$];
    logic [31:0] got_wd[$];
    int          got_done;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        int          stall;
        int          n;
        logic [31:0] a0;
        logic [3:0]  b0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  b1;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: place each store byte at its own byte address, then group by word.
    task automatic model(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] data,
                         input int nb, output int n_out,
                         output logic [31:0] a0, output logic [7:0] b0, output logic [63:0] w0,
                         output logic [31:0] a1, output logic [7:0] b1, output logic [63:0] w1);
        logic [31:0] base, a, w;
        int lane;
        base  = addr & ~32'(nb - 1);
        a0    = base;
        a1    = base + 32'(nb);
        b0    = '0; b1 = '0; w0 = '0; w1 = '0;
        n_out = 1;
        for (int k = 0; k < (1 << size); k++) begin
            a    = addr + 32'(k);
            w    = a & ~32'(nb - 1);
            lane = int'(a & 32'(nb - 1));
            if (w == base) begin
                b0[lane]          = 1'b1;
                w0[8*lane +: 8]   = data[8*k +: 8];
            end else begin
                b1[lane]          = 1'b1;
                w1[8*lane +: 8]   = data[8*k +: 8];
                n_out             = 2;
            end
        end
    endtask

    function automatic int pick_stall(input int stall);
        return (stall < 0) ? int'($urandom_range(0, 2)) : stall;
    endfunction

    // Issue one store on the 32-bit unit and collect its beats, stalling each beat.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [1:0] size,
                                  input logic [31:0] data, input int stall);
        int          stall_left;
        bit          prev_stall, finished;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_be;
        got_addr.delete(); got_be.delete(); got_wd.delete();
        got_done = 0;
        s_addr = '0; s_wd = '0; s_be = '0;
        @(negedge clk);
        check_output("ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_addr = addr; req_size = size; req_data = data;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check_output("latency1", {63'd0, mem_valid}, 64'd1);
        stall_left = pick_stall(stall);
        prev_stall = 1'b0;
        finished   = 1'b0;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            if (done) begin
                got_done++;
                check_output("done_no_valid", {63'd0, mem_valid}, 64'd0);
                finished = 1'b1;
            end else if (mem_valid) begin
                check_output("ready_busy", {63'd0, req_ready}, 64'd0);
                if (prev_stall) begin
                    check_output("stable_addr", mem_addr, s_addr);
                    check_output("stable_be", mem_be, s_be);
                    check_output("stable_wd", mem_wdata, s_wd);
                end
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                    prev_stall = 1'b1;
                    s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata;
                end else begin
                    mem_ready = 1'b1;
                    got_addr.push_back(mem_addr);
                    got_be.push_back(mem_be);
                    got_wd.push_back(mem_wdata);
                    prev_stall = 1'b0;
                    stall_left = pick_stall(stall);
                end
            end else begin
                mem_ready = 1'b0;
            end
            if (!finished) @(negedge clk);
        end
        mem_ready = 1'b0;
        check_output("done_seen", 64'(got_done), 64'd1);
        @(negedge clk);
        check_output("done_single", {63'd0, done}, 64'd0);
    endtask

    task automatic compare_beats(input int n,
                                 input logic [31:0] a0, input logic [7:0] b0, input logic [63:0] w0,
                                 input logic [31:0] a1, input logic [7:0] b1, input logic [63:0] w1);
        check_output("beat_count", 64'(got_addr.size()), 64'(n));
        if (got_addr.size() >= 1) begin
            check_output("b0_addr", got_addr[0], a0);
            check_output("b0_be", got_be[0], b0);
            check_output("b0_wd", got_wd[0], w0);
        end
        if (n == 2 && got_addr.size() >= 2) begin
            check_output("b1_addr", got_addr[1], a1);
            check_output("b1_be", got_be[1], b1);
            check_output("b1_wd", got_wd[1], w1);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] ea0, ea1, ra;
        logic [7:0]  eb0, eb1;
        logic [63:0] ew0, ew1;
        logic [1:0]  rs;
        logic [31:0] rd;

        vecs[0] = '{32'h100, 2'd2, 32'hAABBCCDD, 0, 1, 32'h100, 4'hF, 32'hAABBCCDD, 32'h0, 4'h0, 32'h0};
        vecs[1] = '{32'h103, 2'd0, 32'h000000EE, 0, 1, 32'h100, 4'h8, 32'hEE000000, 32'h0, 4'h0, 32'h0};
        vecs[2] = '{32'h203, 2'd1, 32'h00001234, 0, 2, 32'h200, 4'h8, 32'h34000000, 32'h204, 4'h1, 32'h00000012};
        vecs[3] = '{32'h001, 2'd2, 32'h11223344, 3, 2, 32'h000, 4'hE, 32'h22334400, 32'h004, 4'h1, 32'h00000011};
        vecs[4] = '{32'h102, 2'd1, 32'hFFFF5678, 1, 1, 32'h100, 4'hC, 32'h56780000, 32'h0, 4'h0, 32'h0};
        vecs[5] = '{32'hFFFFFFFE, 2'd2, 32'hA1B2C3D4, -1, 2, 32'hFFFFFFFC, 4'hC, 32'hC3D40000, 32'h0, 4'h3, 32'h0000A1B2};

        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_data = '0; mem_ready = 1'b0;
        w_req_valid = 1'b0; w_req_addr = '0; w_req_size = '0; w_req_data = '0; w_mem_ready = 1'b0;
        #2;
        check_output("rst_valid", {63'd0, mem_valid}, 64'd0);
        check_output("rst_ready", {63'd0, req_ready}, 64'd0);
        check_output("rst_addr", mem_addr, 64'd0);
        check_output("rst_be", mem_be, 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("ready_after_rst", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].stall);
            compare_beats(vecs[i].n, vecs[i].a0, 8'(vecs[i].b0), 64'(vecs[i].w0),
                          vecs[i].a1, 8'(vecs[i].b1), 64'(vecs[i].w1));
        end

        // Oversized request on the 32-bit unit
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; req_size = 2'd3; req_data = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check_output("err_pulse", {63'd0, err}, 64'd1);
        check_output("err_no_valid", {63'd0, mem_valid}, 64'd0);
        @(negedge clk);
        check_output("err_once", {63'd0, err}, 64'd0);
        check_output("err_no_valid2", {63'd0, mem_valid}, 64'd0);
        check_output("err_ready", {63'd0, req_ready}, 64'd1);

        // Reset while the second beat is stalled
        req_valid = 1'b1; req_addr = 32'h1; req_size = 2'd2; req_data = 32'hCAFEF00D;
        mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_output("rs_beat0", {63'd0, mem_valid}, 64'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        check_output("rs_beat1_be", mem_be, 64'h1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("rs_valid", {63'd0, mem_valid}, 64'd0);
        check_output("rs_be", mem_be, 64'd0);
        check_output("rs_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("rs_ready_after", {63'd0, req_ready}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output("rs_no_done", {62'd0, done, mem_valid}, 64'd0);
        end

        // 64-bit unit: dword straddling the top of the address space
        model(32'hFFFFFFFC, 2'd3, 64'h1122334455667788, 8, n, ea0, eb0, ew0, ea1, eb1, ew1);
        @(negedge clk);
        w_req_valid = 1'b1; w_req_addr = 32'hFFFFFFFC; w_req_size = 2'd3;
        w_req_data = 64'h1122334455667788; w_mem_ready = 1'b1;
        @(negedge clk);
        w_req_valid = 1'b0;
        check_output("w_b0_valid", {63'd0, w_mem_valid}, 64'd1);
        check_output("w_b0_addr", w_mem_addr, ea0);
        check_output("w_b0_be", w_mem_be, eb0);
        check_output("w_b0_wd", w_mem_wdata, ew0);
        @(negedge clk);
        check_output("w_b1_valid", {63'd0, w_mem_valid}, 64'd1);
        check_output("w_b1_addr", w_mem_addr, 64'h0);
        check_output("w_b1_be", w_mem_be, eb1);
        check_output("w_b1_wd", w_mem_wdata, ew1);
        @(negedge clk);
        w_mem_ready = 1'b0;
        check_output("w_done", {63'd0, w_done}, 64'd1);
        check_output("w_err", {63'd0, w_err}, 64'd0);

        // Random legal stores against the reference model
        for (int r = 0; r < 40; r++) begin
            ra = $urandom;
            rs = 2'($urandom_range(0, 2));
            rd = $urandom;
            model(ra, rs, 64'(rd), 4, n, ea0, eb0, ew0, ea1, eb1, ew1);
            apply_stimulus(ra, rs, rd, -1);
            compare_beats(n, ea0, eb0, ew0, ea1, eb1, ew1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
